gray_pixel_unpacker: RTL and testbench
======================================

Name: gray_pixel_unpacker

Overview:
- Converts a stream of packed words, each holding LANES grayscale pixels, back into a one-pixel-per-beat stream.
- It is the reverse of the packing path that feeds results to the AXI side. It sits between the DMA read port and the per-pixel arithmetic (adder/weighting) datapath.
- Valid/ready handshake on both sides.
- Supports a partial final word flagged with in_last.

Parameters:
- WORD_W, 32, input word width in bits; must be an integer multiple of PIX_W.
- PIX_W, 8, width of one grayscale pixel.
- LANES, WORD_W/PIX_W (derived localparam, not overridable), pixels per word.

Ports:
- clk  input  1  single system clock, rising edge.
- rst  input  1  reset, asynchronous and active-high.
- in_data  input  WORD_W  packed pixels; lane k occupies bits [k*PIX_W +: PIX_W].
- in_valid  input  1  in_data/in_last/in_cnt are valid.
- in_ready  output  1  block accepts the word this cycle.
- in_last  input  1  this word is the final word of a frame.
- in_cnt  input  $clog2(LANES+1)  number of valid lanes when in_last=1; value 0 is treated as LANES; ignored when in_last=0.
- out_data  output  PIX_W  current pixel.
- out_valid  output  1  out_data valid.
- out_ready  input  1  downstream accepts the pixel.
- out_last  output  1  final pixel of the frame.

Behaviour:
- Reset (async assert, synchronous-release use):
  - out_valid=0, out_data=0, out_last=0, in_ready=0 while rst=1.
  - Internal holding register, lane counter and last flags are cleared.
- Storage: one holding register (word, last flag, lane limit) plus a lane index counter idx (0..LANES-1). No other buffering.
- States: EMPTY, BUSY.
- EMPTY:
  - in_ready=1, out_valid=0.
  - On in_valid&&in_ready: capture word, set idx=0, limit = in_last ? (in_cnt==0 ? LANES : in_cnt) : LANES. Go to BUSY.
- BUSY:
  - out_valid=1, out_data = lane idx of the held word.
  - out_last = held_last && (idx==limit-1).
- Pixel transfer (out_valid&&out_ready):
  - If idx<limit-1: idx increments.
  - If idx==limit-1 (final lane): the word is done.
- in_ready in BUSY = out_ready && (idx==limit-1). It is combinational, so a new word loads in the same cycle the final lane drains.
  - Sustained throughput: one pixel per cycle with no bubbles between words.
  - Latency: first pixel valid one cycle after the word is accepted.
- Final lane drains with no new word: return to EMPTY.
- Backpressure: while out_ready=0, out_data/out_last/out_valid hold stable; idx does not change.
- in_cnt>LANES when in_last=1: clamp to LANES.
- Frame of one word with in_cnt=1: single beat with out_last=1.
- in_valid while BUSY and not on the final lane: no acceptance; the upstream must hold its data (AXI-Stream rule).
- Reset asserted mid-word: remaining pixels are discarded. Outputs go to reset values immediately (asynchronously).

Optional Feature:
- Macro UNPACK_MSB_FIRST_EN.
- Defined: lanes emit from the most significant lane down. Lane order is LANES-1-idx, and a partial last word uses the top in_cnt lanes.
- Undefined: lane 0 (LSBs) first, and a partial word uses the low in_cnt lanes.
- Handshake and timing are identical in both builds.

Decomposition:
- Shared package gray_pkg:
  - PIX_W default constant.
  - Typedef pixel_t (logic [PIX_W-1:0]).
  - Lane-index typedef helper.
  - State enum (EMPTY, BUSY).
- One sub-module, gray_lane_mux: a combinational word + index -> pixel select that contains the MSB-first ordering.
- The FSM, counter and handshake stay in the top block.

Test Plan:
- Reset, then in_data=32'h44332211 with in_valid=1, in_last=0, out_ready=1 -> out_data 11,22,33,44 on consecutive cycles; out_last=0 throughout; in_ready=1 only in the cycle 44 is emitted.
- Back-to-back words 32'h44332211 then 32'h88776655, out_ready=1 held -> 8 contiguous beats 11..88 with no gap.
- in_data=32'hDDCCBBAA with in_last=1, in_cnt=3 -> beats AA, BB, CC; out_last=1 on CC; DD never emitted.
- out_ready toggling 1,0,0,1 on the second lane -> out_data holds 22 stable across the stall; no lane skipped or duplicated.
- Reset pulsed after two pixels of a word -> out_valid=0 immediately; the next word after release starts at lane 0.
- UNPACK_MSB_FIRST_EN build, 32'h44332211 with in_last=1, in_cnt=2 -> beats 44, 33; out_last on 33.

Source files
------------

// File: rtl/gray_pixel_unpacker_pkg.sv
// Shared types for the grayscale pixel unpacker: pixel type, lane-index sizing, FSM states.
package gray_pkg;

  localparam int PIX_W_DEF = 8;
  localparam int WORD_W_DEF = 32;

  typedef logic [PIX_W_DEF-1:0] pixel_t;

  function automatic int idx_w(input int lanes);
    return (lanes > 1) ? $clog2(lanes) : 1;
  endfunction

  typedef logic [idx_w(WORD_W_DEF / PIX_W_DEF)-1:0] lane_idx_t;

  typedef enum logic {EMPTY, BUSY} state_t;

endpackage

// File: rtl/gray_pixel_unpacker_if.sv
// Word-in / pixel-out stream bundle; the unpacker is the slave, the word source the master.
interface gray_pixel_unpacker_if #(
  parameter int WORD_W = 32,
  parameter int PIX_W  = 8
);
  localparam int LANES = WORD_W / PIX_W;
  localparam int CNT_W = $clog2(LANES + 1);

  logic [WORD_W-1:0] in_data;
  logic              in_valid;
  logic              in_ready;
  logic              in_last;
  logic [CNT_W-1:0]  in_cnt;
  logic [PIX_W-1:0]  out_data;
  logic              out_valid;
  logic              out_ready;
  logic              out_last;

  modport slave (
    input  in_data, in_valid, in_last, in_cnt, out_ready,
    output in_ready, out_data, out_valid, out_last
  );

  modport master (
    output in_data, in_valid, in_last, in_cnt, out_ready,
    input  in_ready, out_data, out_valid, out_last
  );
endinterface

// File: rtl/gray_pixel_unpacker_lane_mux.sv
// Word + lane index -> pixel select. UNPACK_MSB_FIRST_EN reverses the lane order.
module gray_lane_mux #(
  parameter int WORD_W = 32,
  parameter int PIX_W  = 8,
  parameter int IDX_W  = 2
) (
  input  logic [WORD_W-1:0] word_i,
  input  logic [IDX_W-1:0]  idx_i,
  output logic [PIX_W-1:0]  pix_o
);
  localparam int LANES = WORD_W / PIX_W;

  logic [IDX_W-1:0] sel;

  always_comb begin
`ifdef UNPACK_MSB_FIRST_EN
    sel = IDX_W'(LANES - 1) - idx_i;
`else
    sel = idx_i;
`endif
    pix_o = word_i[int'(sel)*PIX_W +: PIX_W];
  end

endmodule

// File: rtl/gray_pixel_unpacker.sv
// Unpacks LANES-pixel words into a one-pixel-per-beat stream with a partial final word.
// Optional build macro UNPACK_MSB_FIRST_EN (handled in gray_lane_mux) emits the top lane first.
module gray_pixel_unpacker
  import gray_pkg::*;
#(
  parameter int WORD_W = WORD_W_DEF,
  parameter int PIX_W  = PIX_W_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  gray_pixel_unpacker_if.slave bus
);
  localparam int LANES = WORD_W / PIX_W;
  localparam int IDX_W = idx_w(LANES);
  localparam int CNT_W = $clog2(LANES + 1);

  state_t            state_q, state_d;
  logic [WORD_W-1:0] word_q, word_d;
  logic              last_q, last_d;
  logic [IDX_W-1:0]  lim_q, lim_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              final_lane;
  logic              load;
  logic              in_ready_c;
  logic              out_valid_c;
  logic              out_last_c;
  logic [PIX_W-1:0]  pix;

  // Index of the last lane to emit; cnt of 0 or above LANES means a full word.
  function automatic logic [IDX_W-1:0] lane_limit(input logic last, input logic [CNT_W-1:0] cnt);
    if (!last || cnt == '0 || cnt >= CNT_W'(LANES)) return IDX_W'(LANES - 1);
    return IDX_W'(cnt - CNT_W'(1));
  endfunction

  assign final_lane = (idx_q == lim_q);

  always_comb begin
    state_d     = state_q;
    word_d      = word_q;
    last_d      = last_q;
    lim_d       = lim_q;
    idx_d       = idx_q;
    load        = 1'b0;
    in_ready_c  = 1'b0;
    out_valid_c = 1'b0;
    out_last_c  = 1'b0;
    case (state_q)
      EMPTY: begin
        in_ready_c = 1'b1;
        load       = bus.in_valid;
        if (bus.in_valid) state_d = BUSY;
      end
      BUSY: begin
        out_valid_c = 1'b1;
        out_last_c  = last_q && final_lane;
        in_ready_c  = bus.out_ready && final_lane;
        if (bus.out_ready) begin
          if (!final_lane) begin
            idx_d = idx_q + IDX_W'(1);
          end else begin
            // Refill in the same cycle the final lane drains to avoid a bubble.
            load = bus.in_valid;
            if (!bus.in_valid) state_d = EMPTY;
          end
        end
      end
    endcase
    if (load) begin
      word_d = bus.in_data;
      last_d = bus.in_last;
      lim_d  = lane_limit(bus.in_last, bus.in_cnt);
      idx_d  = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= EMPTY;
      word_q  <= '0;
      last_q  <= 1'b0;
      lim_q   <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      last_q  <= last_d;
      lim_q   <= lim_d;
      idx_q   <= idx_d;
    end
  end

  gray_lane_mux #(
    .WORD_W (WORD_W),
    .PIX_W  (PIX_W),
    .IDX_W  (IDX_W)
  ) u_lane_mux (
    .word_i (word_q),
    .idx_i  (idx_q),
    .pix_o  (pix)
  );

  assign bus.in_ready  = in_ready_c && !rst;
  assign bus.out_valid = out_valid_c;
  assign bus.out_last  = out_last_c;
  assign bus.out_data  = out_valid_c ? pix : '0;

endmodule

// File: tb/tb_gray_pixel_unpacker.sv
// Directed bench for gray_pixel_unpacker; expected lane order follows UNPACK_MSB_FIRST_EN.
module tb_gray_pixel_unpacker;
  import gray_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  gray_pixel_unpacker_if #(.WORD_W(32), .PIX_W(8)) bus ();

  gray_pixel_unpacker #(.WORD_W(32), .PIX_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  function automatic int lane_of(input int idx);
`ifdef UNPACK_MSB_FIRST_EN
    return 3 - idx;
`else
    return idx;
`endif
  endfunction

  function automatic pixel_t exp_pix(input logic [31:0] w, input int idx);
    return w[lane_of(idx)*8 +: 8];
  endfunction

  task automatic present(input logic [31:0] w, input logic last, input logic [2:0] cnt);
    @(negedge clk);
    bus.in_data   = w;
    bus.in_valid  = 1'b1;
    bus.in_last   = last;
    bus.in_cnt    = cnt;
    bus.out_ready = 1'b1;
  endtask

  task automatic test_reset;
    rst           = 1'b1;
    bus.in_data   = '0;
    bus.in_valid  = 1'b0;
    bus.in_last   = 1'b0;
    bus.in_cnt    = '0;
    bus.out_ready = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({bus.out_valid, bus.out_data, bus.out_last, bus.in_ready} !== 11'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: got v=%b d=%h l=%b rdy=%b, want all zero",
               bus.out_valid, bus.out_data, bus.out_last, bus.in_ready);
    end
    rst = 1'b0;
    #1;
    n_checks++;
    if ({bus.out_valid, bus.in_ready} !== 2'b01) begin
      n_fail++;
      $display("FAIL reset_release: got v=%b rdy=%b, want v=0 rdy=1", bus.out_valid, bus.in_ready);
    end
  endtask

  task automatic test_basic;
    logic [31:0] w = 32'h44332211;
    present(w, 1'b0, 3'd0);
    #1;
    n_checks++;
    if ({bus.out_valid, bus.in_ready} !== 2'b01) begin
      n_fail++;
      $display("FAIL basic_empty: got v=%b rdy=%b, want v=0 rdy=1", bus.out_valid, bus.in_ready);
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      bus.in_valid = 1'b0;
      #1;
      n_checks++;
      if ({bus.out_valid, bus.out_data, bus.out_last, bus.in_ready} !== {1'b1, exp_pix(w, i), 1'b0, (i == 3)}) begin
        n_fail++;
        $display("FAIL basic_beat%0d: got v=%b d=%h l=%b rdy=%b, want v=1 d=%h l=0 rdy=%b",
                 i, bus.out_valid, bus.out_data, bus.out_last, bus.in_ready, exp_pix(w, i), (i == 3));
      end
    end
    @(negedge clk);
    #1;
    n_checks++;
    if (bus.out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_drain: got v=%b, want 0", bus.out_valid);
    end
  endtask

  task automatic test_back_to_back;
    logic [31:0] a = 32'h44332211;
    logic [31:0] b = 32'h88776655;
    pixel_t e;
    present(a, 1'b0, 3'd0);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (i == 0) bus.in_data = b;
      if (i == 4) bus.in_valid = 1'b0;
      #1;
      e = (i < 4) ? exp_pix(a, i) : exp_pix(b, i - 4);
      n_checks++;
      if ({bus.out_valid, bus.out_data, bus.out_last, bus.in_ready} !== {1'b1, e, 1'b0, (i == 3 || i == 7)}) begin
        n_fail++;
        $display("FAIL b2b_beat%0d: got v=%b d=%h l=%b rdy=%b, want v=1 d=%h l=0 rdy=%b",
                 i, bus.out_valid, bus.out_data, bus.out_last, bus.in_ready, e, (i == 3 || i == 7));
      end
    end
    @(negedge clk);
    #1;
    n_checks++;
    if (bus.out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_drain: got v=%b, want 0", bus.out_valid);
    end
  endtask

  task automatic test_partial;
    logic [31:0] pw [7] = '{32'hDDCCBBAA, 32'h44332211, 32'hA1B2C3D4, 32'h0F0E0D0C,
                            32'h87654321, 32'h13579BDF, 32'h2468ACE0};
    logic        pl [7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    logic [2:0]  pc [7] = '{3'd3, 3'd2, 3'd1, 3'd0, 3'd7, 3'd5, 3'd1};
    int          pn [7] = '{3, 2, 1, 4, 4, 4, 4};
    logic        lst;
    for (int t = 0; t < 7; t++) begin
      present(pw[t], pl[t], pc[t]);
      for (int i = 0; i < pn[t]; i++) begin
        @(negedge clk);
        bus.in_valid = 1'b0;
        #1;
        lst = pl[t] && (i == pn[t] - 1);
        n_checks++;
        if ({bus.out_valid, bus.out_data, bus.out_last, bus.in_ready} !==
            {1'b1, exp_pix(pw[t], i), lst, (i == pn[t] - 1)}) begin
          n_fail++;
          $display("FAIL partial%0d_beat%0d: got v=%b d=%h l=%b rdy=%b, want v=1 d=%h l=%b rdy=%b",
                   t, i, bus.out_valid, bus.out_data, bus.out_last, bus.in_ready,
                   exp_pix(pw[t], i), lst, (i == pn[t] - 1));
        end
      end
      @(negedge clk);
      #1;
      n_checks++;
      if (bus.out_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL partial%0d_end: got v=%b d=%h, want v=0", t, bus.out_valid, bus.out_data);
      end
    end
  endtask

  task automatic test_backpressure;
    logic [31:0] w = 32'h44332211;
    logic rdy [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    int   ei  [6] = '{0, 1, 1, 1, 2, 3};
    present(w, 1'b0, 3'd0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      bus.in_valid  = 1'b0;
      bus.out_ready = rdy[i];
      #1;
      n_checks++;
      if ({bus.out_valid, bus.out_data, bus.out_last, bus.in_ready} !==
          {1'b1, exp_pix(w, ei[i]), 1'b0, (ei[i] == 3 && rdy[i])}) begin
        n_fail++;
        $display("FAIL stall_cyc%0d: got v=%b d=%h l=%b rdy=%b, want v=1 d=%h l=0 rdy=%b",
                 i, bus.out_valid, bus.out_data, bus.out_last, bus.in_ready,
                 exp_pix(w, ei[i]), (ei[i] == 3 && rdy[i]));
      end
    end
    @(negedge clk);
    #1;
    n_checks++;
    if (bus.out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL stall_drain: got v=%b, want 0", bus.out_valid);
    end
  endtask

  task automatic test_reset_mid;
    logic [31:0] a = 32'h44332211;
    logic [31:0] b = 32'h88776655;
    present(a, 1'b0, 3'd0);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      bus.in_valid = 1'b0;
      #1;
      n_checks++;
      if ({bus.out_valid, bus.out_data} !== {1'b1, exp_pix(a, i)}) begin
        n_fail++;
        $display("FAIL midrst_pre%0d: got v=%b d=%h, want v=1 d=%h", i, bus.out_valid, bus.out_data, exp_pix(a, i));
      end
    end
    @(negedge clk);
    rst = 1'b1;
    #1;
    n_checks++;
    if ({bus.out_valid, bus.out_data, bus.out_last, bus.in_ready} !== 11'b0) begin
      n_fail++;
      $display("FAIL midrst_async: got v=%b d=%h l=%b rdy=%b, want all zero",
               bus.out_valid, bus.out_data, bus.out_last, bus.in_ready);
    end
    @(negedge clk);
    rst = 1'b0;
    bus.in_data  = b;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      bus.in_valid = 1'b0;
      #1;
      n_checks++;
      if ({bus.out_valid, bus.out_data} !== {1'b1, exp_pix(b, i)}) begin
        n_fail++;
        $display("FAIL midrst_post%0d: got v=%b d=%h, want v=1 d=%h", i, bus.out_valid, bus.out_data, exp_pix(b, i));
      end
    end
    @(negedge clk);
    #1;
    n_checks++;
    if (bus.out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL midrst_drain: got v=%b, want 0", bus.out_valid);
    end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_back_to_back;
    test_partial;
    test_backpressure;
    test_reset_mid;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
